// File: rtl/param_stack_if.sv
// ---------------------------------------------------------------------------
// param_stack_if
// Groups the request/response signals of param_stack into one bundle.
//   master : drives clr, push, pop, indata; observes the stack outputs
//   slave  : the stack itself (param_stack)
// Signals:
//   clr        synchronous clear (empties stack, zeroes entries and errors)
//   push/pop   requests sampled every rising clk edge
//   indata     value to push
//   outdata    registered popped value, held until the next accepted pop
//   out_valid  one-cycle strobe, outdata was updated by the last edge
//   top        mem[count-1], zero when empty
//   count      number of valid entries (0..DEPTH)
//   empty/full occupancy flags
//   overflow   sticky, a push was refused while full
//   underflow  sticky, a pop was refused while empty
//   dbg_data   every entry flattened, entry 0 (bottom) in the low bits
// ---------------------------------------------------------------------------
interface param_stack_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 7
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   clr;
  logic                   push;
  logic                   pop;
  logic [WIDTH-1:0]       indata;
  logic [WIDTH-1:0]       outdata;
  logic                   out_valid;
  logic [WIDTH-1:0]       top;
  logic [CW-1:0]          count;
  logic                   empty;
  logic                   full;
  logic                   overflow;
  logic                   underflow;
  logic [DEPTH*WIDTH-1:0] dbg_data;

  modport master (
    output clr, push, pop, indata,
    input  outdata, out_valid, top, count, empty, full, overflow, underflow, dbg_data
  );

  modport slave (
    input  clr, push, pop, indata,
    output outdata, out_valid, top, count, empty, full, overflow, underflow, dbg_data
  );
endinterface

// File: rtl/param_stack.sv
// ---------------------------------------------------------------------------
// param_stack
// Parametrised LIFO stack with registered pop output, replace-top on
// simultaneous push+pop, occupancy count, full/empty flags, sticky
// overflow/underflow errors, synchronous clear and a flattened debug bus.
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  synchronous active-low reset
//   s      param_stack_if slave modport (see interface header for signals)
// Storage grows upward from mem[0]; the top entry is mem[count-1].
// ---------------------------------------------------------------------------
module param_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  param_stack_if.slave  s
);
  localparam int CW = $clog2(DEPTH + 1);
  // Entry index width; count needs one more state (DEPTH) than an index does.
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] outdata_q, outdata_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [CW-1:0]    count_m1;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;
  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign count_m1 = count_q - CW'(1);
  // wr_idx only used when not full, top_idx only when not empty, so the
  // truncation to AW bits never drops a meaningful bit.
  assign wr_idx   = count_q[AW-1:0];
  assign top_idx  = count_m1[AW-1:0];

  always_comb begin
    mem_d       = mem_q;
    count_d     = count_q;
    outdata_d   = outdata_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (s.clr) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      count_d     = '0;
      outdata_d   = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      unique case ({s.push, s.pop})
        2'b10: begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_d[wr_idx] = s.indata;
            count_d       = count_q + CW'(1);
          end
        end
        2'b01: begin
          if (is_empty) begin
            underflow_d = 1'b1;
          end else begin
            outdata_d   = mem_q[top_idx];
            out_valid_d = 1'b1;
            count_d     = count_m1;
          end
        end
        2'b11: begin
          if (is_empty) begin
            // Push still lands in the bottom slot; only the pop is refused.
            mem_d[0]    = s.indata;
            count_d     = CW'(1);
            underflow_d = 1'b1;
          end else begin
            // Replace-top: old top leaves through outdata, new value takes its slot.
            outdata_d      = mem_q[top_idx];
            out_valid_d    = 1'b1;
            mem_d[top_idx] = s.indata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q     <= '0;
      outdata_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      count_q     <= count_d;
      outdata_q   <= outdata_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign s.outdata   = outdata_q;
  assign s.out_valid = out_valid_q;
  assign s.count     = count_q;
  assign s.empty     = is_empty;
  assign s.full      = is_full;
  assign s.overflow  = overflow_q;
  assign s.underflow = underflow_q;
  assign s.top       = is_empty ? '0 : mem_q[top_idx];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dbg
    assign s.dbg_data[gi*WIDTH +: WIDTH] = mem_q[gi];
  end
endmodule

// File: tb/tb_param_stack.sv
module tb_param_stack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_stack_if #(.WIDTH(10), .DEPTH(7))  bus ();
  param_stack_if #(.WIDTH(16), .DEPTH(16)) bus16 ();

  param_stack #(.WIDTH(10), .DEPTH(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  param_stack #(.WIDTH(16), .DEPTH(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus16)
  );

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic [9:0] din;
    int         cnt;
    logic [9:0] top;
    logic [9:0] out;
    logic       vld;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic p, input logic q, input logic c, input logic [9:0] d);
    @(negedge clk);
    bus.push = p; bus.pop = q; bus.clr = c; bus.indata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic p, input logic q, input logic c, input int d, input int cnt,
                     input int top, input int out, input logic vld, input logic ovf, input logic unf);
    vec_t v;
    v.push = p; v.pop = q; v.clr = c; v.din = 10'(d); v.cnt = cnt;
    v.top = 10'(top); v.out = 10'(out); v.vld = vld; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  logic [69:0] exp_dbg;

  initial begin
    bus.push = 1'b0; bus.pop = 1'b0; bus.clr = 1'b0; bus.indata = '0;
    bus16.push = 1'b0; bus16.pop = 1'b0; bus16.clr = 1'b0; bus16.indata = '0;

    // Vector table: push, pop, clr, indata -> count, top, outdata, out_valid, ovf, unf
    add(1,0,0,'h155, 1,'h155,0,0,0,0);
    add(0,0,1,0,     0,0,0,0,0,0);
    for (int k = 1; k <= 7; k++) add(1,0,0,k, k,k,0,0,0,0);
    add(1,0,0,8,     7,7,0,0,1,0);
    for (int j = 1; j <= 7; j++) add(0,1,0,0, 7-j,7-j,8-j,1,1,0);
    add(0,1,0,0,     0,0,1,0,1,1);
    add(0,0,0,0,     0,0,1,0,1,1);
    add(1,0,1,9,     0,0,0,0,0,0);
    add(1,0,0,3,     1,3,0,0,0,0);
    add(1,0,0,9,     2,9,0,0,0,0);
    add(1,1,0,5,     2,5,9,1,0,0);
    add(0,0,0,0,     2,5,9,0,0,0);
    for (int k = 10; k <= 14; k++) add(1,0,0,k, k-7,k,9,0,0,0);
    add(1,1,0,15,    7,15,14,1,0,0);
    add(0,0,1,0,     0,0,0,0,0,0);
    add(1,1,0,4,     1,4,0,0,0,1);
    add(1,0,0,6,     2,6,0,0,0,1);
    add(0,1,0,0,     1,4,6,1,0,1);

    // Reset held two cycles with a push request pending
    rst_n = 1'b0;
    step(1, 0, 0, 10'h3ff);
    step(1, 0, 0, 10'h3ff);
    chk("rst_count",   128'(bus.count), 128'(0));
    chk("rst_empty",   128'(bus.empty), 128'(1));
    chk("rst_full",    128'(bus.full), 128'(0));
    chk("rst_dbg",     128'(bus.dbg_data), 128'(0));
    chk("rst_outdata", 128'(bus.outdata), 128'(0));
    chk("rst_top",     128'(bus.top), 128'(0));
    chk("rst_flags",   128'({bus.out_valid, bus.overflow, bus.underflow}), 128'(0));
    step(0, 0, 0, 10'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
      $display("vec %0d: push=%0b pop=%0b clr=%0b din=%0h -> count=%0d top=%0h out=%0h v=%0b ovf=%0b unf=%0b",
               i, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din, bus.count, bus.top,
               bus.outdata, bus.out_valid, bus.overflow, bus.underflow);
      chk($sformatf("v%0d_count", i), 128'(bus.count), 128'(vecs[i].cnt));
      chk($sformatf("v%0d_top", i),   128'(bus.top), 128'(vecs[i].top));
      chk($sformatf("v%0d_out", i),   128'(bus.outdata), 128'(vecs[i].out));
      chk($sformatf("v%0d_valid", i), 128'(bus.out_valid), 128'(vecs[i].vld));
      chk($sformatf("v%0d_ovf", i),   128'(bus.overflow), 128'(vecs[i].ovf));
      chk($sformatf("v%0d_unf", i),   128'(bus.underflow), 128'(vecs[i].unf));
      chk($sformatf("v%0d_empty", i), 128'(bus.empty), 128'(vecs[i].cnt == 0));
      chk($sformatf("v%0d_full", i),  128'(bus.full), 128'(vecs[i].cnt == 7));
    end

    // Debug bus: fill, overflow, partial drain keeps vacated entries, clr wipes
    step(0, 0, 1, 10'h0);
    exp_dbg = '0;
    for (int k = 1; k <= 7; k++) begin
      step(1, 0, 0, 10'(k));
      exp_dbg[(k-1)*10 +: 10] = 10'(k);
    end
    $display("seq fill: count=%0d dbg=%0h", bus.count, bus.dbg_data);
    chk("fill_dbg", 128'(bus.dbg_data), 128'(exp_dbg));
    step(1, 0, 0, 10'd8);
    $display("seq overflow: count=%0d ovf=%0b", bus.count, bus.overflow);
    chk("ovf_dbg", 128'(bus.dbg_data), 128'(exp_dbg));
    chk("ovf_flag", 128'(bus.overflow), 128'(1));
    for (int j = 0; j < 4; j++) step(0, 1, 0, 10'h0);
    $display("seq drain4: count=%0d out=%0h dbg=%0h", bus.count, bus.outdata, bus.dbg_data);
    chk("drain_count", 128'(bus.count), 128'(3));
    chk("drain_out",   128'(bus.outdata), 128'(4));
    chk("drain_dbg",   128'(bus.dbg_data), 128'(exp_dbg));
    chk("drain_ovf",   128'(bus.overflow), 128'(1));
    step(1, 0, 1, 10'h2aa);
    $display("seq clr+push: count=%0d dbg=%0h ovf=%0b", bus.count, bus.dbg_data, bus.overflow);
    chk("clr_count", 128'(bus.count), 128'(0));
    chk("clr_dbg",   128'(bus.dbg_data), 128'(0));
    chk("clr_ovf",   128'(bus.overflow), 128'(0));
    chk("clr_top",   128'(bus.top), 128'(0));
    step(0, 0, 0, 10'h0);

    // WIDTH=16, DEPTH=16 instance: full at 16 with a 5-bit count
    chk("w16_cw", 128'($bits(bus16.count)), 128'(5));
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bus16.push = 1'b1; bus16.indata = 16'(k * 16'h0101);
      @(posedge clk);
      #1;
      if (k == 15) chk("w16_not_full", 128'(bus16.full), 128'(0));
    end
    $display("seq w16 fill: count=%0d full=%0b top=%0h", bus16.count, bus16.full, bus16.top);
    chk("w16_count", 128'(bus16.count), 128'(16));
    chk("w16_full",  128'(bus16.full), 128'(1));
    chk("w16_top",   128'(bus16.top), 128'(16'h1010));
    @(negedge clk);
    bus16.indata = 16'hbeef;
    @(posedge clk);
    #1;
    $display("seq w16 overflow: count=%0d ovf=%0b top=%0h", bus16.count, bus16.overflow, bus16.top);
    chk("w16_ovf",      128'(bus16.overflow), 128'(1));
    chk("w16_ovf_cnt",  128'(bus16.count), 128'(16));
    chk("w16_ovf_top",  128'(bus16.top), 128'(16'h1010));
    @(negedge clk);
    bus16.push = 1'b0; bus16.pop = 1'b1;
    @(posedge clk);
    #1;
    $display("seq w16 pop: count=%0d out=%0h v=%0b", bus16.count, bus16.outdata, bus16.out_valid);
    chk("w16_pop_out", 128'(bus16.outdata), 128'(16'h1010));
    chk("w16_pop_vld", 128'(bus16.out_valid), 128'(1));
    chk("w16_pop_cnt", 128'(bus16.count), 128'(15));
    @(negedge clk);
    bus16.pop = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
